// File: rtl/sram_addr_ctrl_pkg.sv
// Shared types and widths for the SRAM row-address controller and its phase timer.
package sram_addr_ctrl_pkg;

  localparam int ADDR_W  = 9;
  localparam int FIELD_W = 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_PRECH  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing the ACCESS and PRECH phases; o_zero marks the last phase cycle.
module sram_phase_timer
  import sram_addr_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_addr_ctrl.sv
// SRAM row-address controller: latches a row address for the external predecoders and
// sequences SETUP -> ACCESS (wordline) -> PRECH (bitline precharge) per request.
module sram_addr_ctrl
  import sram_addr_ctrl_pkg::*;
#(
  parameter int ACCESS_CYC = 2,
  parameter int PRECH_CYC  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ADDR_W-1:0]  i_req_addr,
  input  logic               i_req_we,
  output logic [FIELD_W-1:0] o_pre_a,
  output logic [FIELD_W-1:0] o_pre_b,
  output logic [FIELD_W-1:0] o_pre_c,
  output logic               o_wl_en,
  output logic               o_precharge,
  output logic               o_we_out,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] PRC_LOAD = CNT_W'(PRECH_CYC - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              w_handshake;
  logic              w_tmr_load;
  logic              w_tmr_dec;
  logic              w_tmr_zero;
  logic [CNT_W-1:0]  w_tmr_val;

  assign w_handshake = i_req_valid && (r_state == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_tmr_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) begin
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
        w_tmr_load   = 1'b1;
        w_tmr_val    = ACC_LOAD;
      end
      ST_ACCESS: begin
        if (w_tmr_zero) begin
          w_state_next = ST_PRECH;
          w_tmr_load   = 1'b1;
          w_tmr_val    = PRC_LOAD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_PRECH: begin
        if (w_tmr_zero) begin
          w_state_next = ST_IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the async-reset state register, so reset kills wl_en at once.
  always_comb begin
    o_req_ready = 1'b0;
    o_wl_en     = 1'b0;
    o_precharge = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_precharge = 1'b1;
        o_busy      = 1'b0;
      end
      ST_SETUP: begin
      end
      ST_ACCESS: begin
        o_wl_en = 1'b1;
      end
      ST_PRECH: begin
        o_precharge = 1'b1;
        o_done      = w_tmr_zero;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_we   <= 1'b0;
    end else if (w_handshake) begin
      r_addr <= i_req_addr;
      r_we   <= i_req_we;
    end
  end

  assign o_pre_a  = r_addr[FIELD_W-1:0];
  assign o_pre_b  = r_addr[2*FIELD_W-1:FIELD_W];
  assign o_pre_c  = r_addr[3*FIELD_W-1:2*FIELD_W];
  assign o_we_out = r_we;

  sram_phase_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

endmodule

// File: tb/tb_sram_addr_ctrl.sv
// Bench for sram_addr_ctrl: two instances (default timing and 4/3 timing) checked every
// cycle against a model based on cycles elapsed since each accepted request.
module tb_sram_addr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       valid;
  logic [1:0]       we;
  logic [1:0][8:0]  addr;
  logic [1:0]       ready, wl, prech, we_o, busy, done;
  logic [1:0][2:0]  pa, pb, pc;

  sram_addr_ctrl #(.ACCESS_CYC(2), .PRECH_CYC(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_valid(valid[0]), .o_req_ready(ready[0]),
    .i_req_addr(addr[0]), .i_req_we(we[0]), .o_pre_a(pa[0]), .o_pre_b(pb[0]), .o_pre_c(pc[0]),
    .o_wl_en(wl[0]), .o_precharge(prech[0]), .o_we_out(we_o[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  sram_addr_ctrl #(.ACCESS_CYC(4), .PRECH_CYC(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_valid(valid[1]), .o_req_ready(ready[1]),
    .i_req_addr(addr[1]), .i_req_we(we[1]), .o_pre_a(pa[1]), .o_pre_b(pb[1]), .o_pre_c(pc[1]),
    .o_wl_en(wl[1]), .o_precharge(prech[1]), .o_we_out(we_o[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  // Model: a request accepted at edge k occupies the block for 1+A+P cycles after that edge.
  int         acc_cyc [2] = '{2, 4};
  int         prc_cyc [2] = '{1, 3};
  bit         active  [2];
  int         k_edge  [2];
  logic [8:0] m_addr  [2];
  logic       m_we    [2];
  logic       prev_done [2];
  int         edge_n = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic bit m_busy(int i);
    return active[i] && ((edge_n - k_edge[i]) <= acc_cyc[i] + prc_cyc[i]);
  endfunction

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d edge %0d: got %0h expected %0h", name, inst, edge_n, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int   d;
      bit   b;
      logic [14:0] exp_v, act_v;
      d = edge_n - k_edge[i];
      b = m_busy(i);
      exp_v = {!b, b && d >= 1 && d <= acc_cyc[i], !b || d > acc_cyc[i],
               b && d == acc_cyc[i] + prc_cyc[i], b, m_we[i], m_addr[i]};
      act_v = {ready[i], wl[i], prech[i], done[i], busy[i], we_o[i], pc[i], pb[i], pa[i]};
      check("outs", i, 32'(act_v), 32'(exp_v));
      check("wl_prech_excl", i, 32'(wl[i] & prech[i]), 32'd0);
      check("done_pulse", i, 32'(prev_done[i] & done[i]), 32'd0);
      prev_done[i] = done[i];
      $display("[TB] inst%0d edge %0d v=%0b addr=%03h busy=%0b wl=%0b pre=%0b done=%0b",
               i, edge_n, valid[i], addr[i], busy[i], wl[i], prech[i], done[i]);
    end
  endtask

  task automatic step();
    bit idle_before [2];
    @(posedge clk);
    for (int i = 0; i < 2; i++) idle_before[i] = !m_busy(i);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        active[i] = 1'b0;
        m_addr[i] = '0;
        m_we[i]   = 1'b0;
      end else if (idle_before[i] && valid[i]) begin
        active[i] = 1'b1;
        k_edge[i] = edge_n;
        m_addr[i] = addr[i];
        m_we[i]   = we[i];
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  int wl_cnt [2];
  int busy_cnt [2];
  int prb_cnt [2];
  int done_at [2];
  int done_cnt;
  int last_k;
  int n_acc;
  bit got;
  logic [8:0] seq [3];

  initial begin
    rst_n = 2'b00; valid = 2'b00; we = 2'b00; addr[0] = '0; addr[1] = '0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; k_edge[i] = 0; m_addr[i] = '0; m_we[i] = 1'b0; prev_done[i] = 1'b0;
    end
    step();
    step();
    for (int i = 0; i < 2; i++)
      check("rst_state", i, 32'({ready[i], wl[i], prech[i], done[i], busy[i], we_o[i], pc[i], pb[i], pa[i]}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0}));
    rst_n = 2'b11;
    step();

    // Single read on inst0 and single write on inst1, issued together.
    valid = 2'b11; addr[0] = 9'b101_011_001; we[0] = 1'b0; addr[1] = 9'h155; we[1] = 1'b1;
    step();
    valid = 2'b00;
    check("pre_a_lit", 0, 32'(pa[0]), 32'(3'b001));
    check("pre_b_lit", 0, 32'(pb[0]), 32'(3'b011));
    check("pre_c_lit", 0, 32'(pc[0]), 32'(3'b101));
    check("we_out_lit", 1, 32'(we_o[1]), 32'd1);
    for (int i = 0; i < 2; i++) begin wl_cnt[i] = 0; busy_cnt[i] = 0; prb_cnt[i] = 0; done_at[i] = -1; end
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 2; i++) begin
        wl_cnt[i]   += int'(wl[i]);
        busy_cnt[i] += int'(busy[i]);
        prb_cnt[i]  += int'(prech[i] & busy[i]);
        if (done[i]) done_at[i] = j;
      end
      step();
    end
    check("wl_cnt_lit", 0, 32'(wl_cnt[0]), 32'd2);
    // d=3 after the accept edge is the 5th cycle counting the handshake cycle as the 1st.
    check("done_at_lit", 0, 32'(done_at[0]), 32'd3);
    check("wl_cnt_lit", 1, 32'(wl_cnt[1]), 32'd4);
    check("prech_cnt_lit", 1, 32'(prb_cnt[1]), 32'd3);
    check("busy_cnt_lit", 1, 32'(busy_cnt[1]), 32'd8);

    // Back-to-back on inst0 with valid held: accepts must be exactly 5 edges apart.
    seq[0] = 9'h000; seq[1] = 9'h1FF; seq[2] = 9'h0AA;
    n_acc = 0; last_k = -1;
    valid[0] = 1'b1; addr[0] = seq[0]; we[0] = 1'b0;
    for (int j = 0; j < 30 && n_acc < 3; j++) begin
      step();
      if (active[0] && k_edge[0] == edge_n) begin
        if (last_k >= 0) check("b2b_gap_lit", 0, 32'(k_edge[0] - last_k), 32'd5);
        last_k = k_edge[0];
        n_acc++;
        if (n_acc < 3) addr[0] = seq[n_acc];
      end else begin
        addr[0] = 9'(addr[0] ^ 9'h013);
        addr[0] = (n_acc > 0) ? addr[0] : seq[0];
      end
    end
    check("b2b_accepts", 0, 32'(n_acc), 32'd3);
    valid[0] = 1'b0;
    for (int j = 0; j < 6; j++) step();

    // Reset pulled during the 2nd ACCESS cycle of inst0.
    valid[0] = 1'b1; addr[0] = 9'h0C3; we[0] = 1'b1;
    got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      step();
      got = active[0] && (k_edge[0] == edge_n);
    end
    check("rst_test_accept", 0, 32'(got), 32'd1);
    valid[0] = 1'b0;
    step();
    step();
    rst_n[0] = 1'b0;
    #1;
    check("rst_async", 0, 32'({wl[0], prech[0], done[0], busy[0], we_o[0], pc[0], pb[0], pa[0]}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0}));
    active[0] = 1'b0; m_addr[0] = '0; m_we[0] = 1'b0; prev_done[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    valid[0] = 1'b1; addr[0] = 9'h0F0; we[0] = 1'b0;
    step();
    valid[0] = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < 7; j++) begin
      done_cnt += int'(done[0]);
      step();
    end
    check("post_rst_done_lit", 0, 32'(done_cnt), 32'd1);

    // Randomised traffic on both instances, addresses also changing while busy.
    for (int j = 0; j < 800; j++) begin
      for (int i = 0; i < 2; i++) begin
        valid[i] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) addr[i] = 9'($urandom_range(0, 511));
        we[i] = 1'($urandom_range(0, 1));
      end
      step();
    end
    valid = 2'b00;
    for (int j = 0; j < 10; j++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
